// File: rtl/apb_pkg.sv
// Shared APB definitions for the APB request master.
//   apb_state_e : requester FSM states (IDLE, SETUP, ACCESS, RESP)
//   APB_DATA_W  : APB data bus width
//   APB_STRB_W  : APB byte-strobe width
//   APB_PROT_W  : APB protection attribute width
package apb_pkg;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = APB_DATA_W / 8;
  localparam int unsigned APB_PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_req_master.sv
// APB4 requester: turns a valid/ready request into one APB transfer and
// returns the result on a valid/ready response channel. An ACCESS phase that
// runs TIMEOUT_CYC cycles without p_ready is abandoned with an error.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_addr/write/wdata/strb/prot, req_vld -> req_rdy   request channel
//   rsp_rdata, rsp_err, rsp_vld <- rsp_rdy               response channel
//   p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb   APB outputs
//   p_ready, p_rdata, p_slverr                           APB completer inputs
module apb_req_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_strb,
  input  logic [APB_PROT_W-1:0] req_prot,
  input  logic                  req_vld,
  output logic                  req_rdy,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [ADDR_W-1:0]     p_addr,
  output logic [APB_PROT_W-1:0] p_prot,
  output logic                  p_sel,
  output logic                  p_enable,
  output logic                  p_write,
  output logic [APB_DATA_W-1:0] p_wdata,
  output logic [APB_STRB_W-1:0] p_strb,
  input  logic                  p_ready,
  input  logic [APB_DATA_W-1:0] p_rdata,
  input  logic                  p_slverr
);

  // Counter is at least one bit wide so TIMEOUT_CYC = 0 still elaborates.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '1;

  apb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // The counter holds the number of waited ACCESS cycles so far; this cycle
  // is the TIMEOUT_CYC-th one when it equals TIMEOUT_CYC-1.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == CNT_LAST);

  // Gated by rst_n so the request side is closed while reset is held.
  assign req_rdy = (state == IDLE) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_vld   <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      p_sel     <= 1'b0;
      p_enable  <= 1'b0;
      p_write   <= 1'b0;
      p_addr    <= '0;
      p_wdata   <= '0;
      p_strb    <= '0;
      p_prot    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_vld) begin
            state    <= SETUP;
            p_sel    <= 1'b1;
            p_addr   <= req_addr;
            p_write  <= req_write;
            p_wdata  <= req_wdata;
            p_prot   <= req_prot;
            p_strb   <= req_write ? req_strb : '0;
            wait_cnt <= '0;
          end
        end

        SETUP: begin
          state    <= ACCESS;
          p_enable <= 1'b1;
        end

        ACCESS: begin
          if (!p_ready && (wait_cnt != CNT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          // Completion takes priority over a timeout in the same cycle.
          if (p_ready) begin
            state     <= RESP;
            p_sel     <= 1'b0;
            p_enable  <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_rdata <= p_write ? '0 : p_rdata;
            rsp_err   <= p_slverr;
          end else if (timeout_hit) begin
            state     <= RESP;
            p_sel     <= 1'b0;
            p_enable  <= 1'b0;
            rsp_vld   <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end

        RESP: begin
          if (rsp_rdy) begin
            state   <= IDLE;
            rsp_vld <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [15:0] p_addr;
  logic [2:0]  p_prot;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic        p_ready;
  logic [31:0] p_rdata;
  logic        p_slverr;

  apb_req_master #(.ADDR_W(16), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot), .req_vld(req_vld), .req_rdy(req_rdy),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .p_addr(p_addr), .p_prot(p_prot), .p_sel(p_sel), .p_enable(p_enable),
    .p_write(p_write), .p_wdata(p_wdata), .p_strb(p_strb),
    .p_ready(p_ready), .p_rdata(p_rdata), .p_slverr(p_slverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;     // ACCESS cycles before p_ready; >= 4 never readies
    logic        rdy_setup;  // stray p_ready during SETUP
    logic [31:0] rdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_acc;    // expected number of ACCESS cycles
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[7];
  rsp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_payload(input string tag, input vec_t v);
    logic [3:0] exp_strb;
    exp_strb = v.write ? v.strb : 4'h0;
    chk({tag, "_p_addr"},  32'(p_addr),  32'(v.addr));
    chk({tag, "_p_write"}, 32'(p_write), 32'(v.write));
    chk({tag, "_p_wdata"}, p_wdata,      v.wdata);
    chk({tag, "_p_strb"},  32'(p_strb),  32'(exp_strb));
    chk({tag, "_p_prot"},  32'(p_prot),  32'(v.prot));
  endtask

  // Called at a sample point (#1 after an edge) with the DUT in IDLE.
  task automatic run_xfer(input vec_t v, input int hold);
    rsp_t e;
    int   acc;
    chk("idle_req_rdy", 32'(req_rdy), 32'd1);
    req_vld   = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_prot  = v.prot;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble request inputs so an unregistered payload shows up.
    req_vld   = 1'b0;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    req_strb  = ~v.strb;
    req_prot  = ~v.prot;
    req_write = ~v.write;
    chk("setup_p_sel",    32'(p_sel),    32'd1);
    chk("setup_p_enable", 32'(p_enable), 32'd0);
    chk("setup_req_rdy",  32'(req_rdy),  32'd0);
    chk("setup_rsp_vld",  32'(rsp_vld),  32'd0);
    chk_payload("setup", v);
    p_ready  = v.rdy_setup;
    p_rdata  = v.rdata;
    p_slverr = v.slverr;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      p_ready = 1'b0;
      if (!(p_sel === 1'b1 && p_enable === 1'b1)) break;
      acc++;
      chk_payload("access", v);
      p_ready = (k == v.wait_n);
    end
    chk("access_cycles", 32'(acc), 32'(v.exp_acc));
    chk("resp_rsp_vld",  32'(rsp_vld),  32'd1);
    chk("resp_p_sel",    32'(p_sel),    32'd0);
    chk("resp_p_enable", 32'(p_enable), 32'd0);
    chk("resp_p_addr_held", 32'(p_addr), 32'(v.addr));
    if (rsp_vld === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err",   32'(rsp_err), 32'(e.err));
      end
    end
    for (int h = 0; h < hold; h++) begin
      rsp_rdy = 1'b0;
      req_vld = 1'b1;
      p_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_rsp_vld",   32'(rsp_vld),   32'd1);
      chk("hold_req_rdy",   32'(req_rdy),   32'd0);
      chk("hold_p_sel",     32'(p_sel),     32'd0);
      chk("hold_rsp_rdata", rsp_rdata,      v.exp_rdata);
      chk("hold_rsp_err",   32'(rsp_err),   32'(v.exp_err));
    end
    p_ready = 1'b0;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    chk("post_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("post_req_rdy", 32'(req_rdy), 32'd1);
    chk("post_p_sel",   32'(p_sel),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr      wdata         strb  prot  wait rdys rdata         slverr exp_rdata     exp_err acc
    vecs[0] = '{1'b0, 16'h0010, 32'h0000_0000, 4'h0, 3'd0, 0,   1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1};
    vecs[1] = '{1'b1, 16'h0004, 32'hA5A5_A5A5, 4'h3, 3'd1, 3,   1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 4};
    vecs[2] = '{1'b0, 16'h0008, 32'h1111_1111, 4'hF, 3'd2, 1,   1'b1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 2};
    vecs[3] = '{1'b1, 16'h0100, 32'h0F0F_0F0F, 4'hC, 3'd3, 99,  1'b0, 32'h7777_7777, 1'b0, 32'h0000_0000, 1'b1, 4};
    vecs[4] = '{1'b0, 16'h0200, 32'h0000_0000, 4'h0, 3'd4, 99,  1'b0, 32'h55AA_55AA, 1'b0, 32'h0000_0000, 1'b1, 4};
    vecs[5] = '{1'b1, 16'hFFFC, 32'h0000_0000, 4'hF, 3'd7, 3,   1'b0, 32'h9999_9999, 1'b1, 32'h0000_0000, 1'b1, 4};
    vecs[6] = '{1'b0, 16'h1234, 32'hFFFF_FFFF, 4'h5, 3'd5, 2,   1'b0, 32'h0BAD_BEEF, 1'b0, 32'h0BAD_BEEF, 1'b0, 3};

    rst_n = 1'b1; req_vld = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; rsp_rdy = 1'b0; p_ready = 1'b0; p_rdata = '0; p_slverr = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_req_rdy",  32'(req_rdy),  32'd0);
    chk("rst_p_sel",    32'(p_sel),    32'd0);
    chk("rst_p_enable", 32'(p_enable), 32'd0);
    chk("rst_rsp_vld",  32'(rsp_vld),  32'd0);
    chk("rst_rsp_err",  32'(rsp_err),  32'd0);
    chk("rst_rsp_rdata", rsp_rdata,    32'd0);
    chk("rst_p_addr",   32'(p_addr),   32'd0);
    chk("rst_p_wdata",  p_wdata,       32'd0);
    chk("rst_p_strb",   32'(p_strb),   32'd0);
    chk("rst_p_prot",   32'(p_prot),   32'd0);
    chk("rst_p_write",  32'(p_write),  32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_rdy", 32'(req_rdy), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], 0);

    // Response backpressure with a pending request, then that request goes through.
    run_xfer(vecs[0], 5);
    run_xfer(vecs[6], 0);

    // Reset in the middle of ACCESS: transfer vanishes without a response.
    req_vld = 1'b1; req_write = 1'b0; req_addr = 16'h0040; req_strb = 4'h0; req_prot = 3'd0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(posedge clk); #1;
    chk("mid_access_p_sel",    32'(p_sel),    32'd1);
    chk("mid_access_p_enable", 32'(p_enable), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_p_sel",    32'(p_sel),    32'd0);
    chk("midrst_p_enable", 32'(p_enable), 32'd0);
    chk("midrst_rsp_vld",  32'(rsp_vld),  32'd0);
    chk("midrst_req_rdy",  32'(req_rdy),  32'd0);
    chk("midrst_p_addr",   32'(p_addr),   32'd0);
    #2 rst_n = 1'b1;
    p_ready = 1'b1; p_rdata = 32'hFFFF_0000;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("postrst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("postrst_p_sel",   32'(p_sel),   32'd0);
      chk("postrst_req_rdy", 32'(req_rdy), 32'd1);
    end
    p_ready = 1'b0;
    chk("postrst_sb_empty", 32'(sb.size()), 32'd0);
    run_xfer(vecs[1], 0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_req_master.md
APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the APB address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 256, the maximum number of ACCESS cycles per transfer; 0 disables the timeout.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_addr  input  ADDR_W  request address.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_wdata  input  32  write data.
REQ-008 req_strb  input  4  byte strobes, write only.
REQ-009 req_prot  input  3  protection attributes.
REQ-010 req_vld / req_rdy  input / output  1 / 1  request handshake.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-012 rsp_err  output  1  slave error or timeout.
REQ-013 rsp_vld / rsp_rdy  output / input  1 / 1  response handshake.
REQ-014 p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb  output  ADDR_W, 3, 1, 1, 1, 32, 4  APB4 requester outputs.
REQ-015 p_ready, p_rdata, p_slverr  input  1, 32, 1  APB4 completer responses.

Function
REQ-016 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP.
REQ-017 req_rdy SHALL be 1 only in IDLE. A transfer is accepted when req_vld && req_rdy, and the FSM then goes IDLE->SETUP.
REQ-018 On accept, the block SHALL register addr, write, wdata, prot and strb. p_strb SHALL be forced to 0 for reads.
REQ-019 SETUP SHALL last exactly one cycle with p_sel=1 and p_enable=0, then go to ACCESS.
REQ-020 In ACCESS, p_sel and p_enable SHALL both be 1. All APB payload outputs SHALL be held stable from SETUP through the last ACCESS cycle.
REQ-021 p_ready SHALL be sampled only in ACCESS; a p_ready seen in IDLE, SETUP or RESP SHALL be ignored.
REQ-022 ACCESS with p_ready=1 SHALL go to RESP on the next cycle and capture the response:
- rsp_rdata = p_rdata for reads, 0 for writes;
- rsp_err = p_slverr.
REQ-023 A wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with p_ready=0; it is $clog2(TIMEOUT_CYC+1) bits wide and never wraps.
REQ-024 When the counter reaches TIMEOUT_CYC (TIMEOUT_CYC>0) and p_ready=0, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0, and drive p_sel=p_enable=0 from the next cycle.
REQ-025 If p_ready=1 in the cycle the counter reaches TIMEOUT_CYC, the completion SHALL win and no timeout is reported.
REQ-026 In RESP, rsp_vld SHALL be 1 with stable rsp_rdata and rsp_err until rsp_rdy=1; the FSM then goes to IDLE.
REQ-027 Minimum latency SHALL be: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_vld at 3. Throughput SHALL be at most one transfer per 4 cycles.
REQ-028 Outside SETUP and ACCESS, p_sel=p_enable=0, and the payload outputs SHALL keep their last values.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously clear all of the following to 0, with FSM=IDLE:
- rsp_vld, rsp_err, rsp_rdata;
- p_sel, p_enable, p_write, p_addr, p_wdata, p_strb, p_prot;
- the wait counter.
REQ-030 req_rdy SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-031 A transfer in flight at reset SHALL be discarded without a response.

Structure
REQ-032 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS/RESP) and the APB data/strobe/prot width constants.
REQ-033 The block SHALL be a single module with no sub-module; the FSM and the counter live inline.

Verification
REQ-034 Read 0x0010, slave p_ready at the first ACCESS cycle, p_rdata=0x1234_5678 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_vld at cycle 3, rsp_rdata=0x1234_5678, rsp_err=0.
REQ-035 Write 0x0004, wdata=0xA5A5_A5A5, strb=0x3, slave waits 3 cycles -> p_strb=0x3, payload stable for 4 ACCESS cycles, rsp_rdata=0, rsp_err=0.
REQ-036 Read with p_strb check and p_slverr=1 at completion -> p_strb=0 throughout, rsp_err=1, rsp_rdata equals p_rdata.
REQ-037 TIMEOUT_CYC=4, slave never ready -> rsp_err=1, rsp_rdata=0 after 4 ACCESS cycles, p_sel drops. Repeat with p_ready arriving on the 4th ACCESS cycle -> rsp_err=0.
REQ-038 Hold rsp_rdy=0 for 5 cycles with req_vld=1 -> rsp_vld held, req_rdy=0, no new p_sel. Release rsp_rdy -> IDLE, and the next request is accepted.
REQ-039 Assert rst_n low during ACCESS -> p_sel, p_enable and rsp_vld are 0 immediately, and no response is produced after release.
